// File: rtl/adder_alu16b_if.sv
// Operand/result bundle for the registered 16-bit adder with ALU status flags.
// The master drives the operands; the slave (the adder) returns the sum and flags.
interface adder_alu16b_if;
  logic [15:0] X;
  logic [15:0] Y;
  logic [15:0] sum;
  logic        S;
  logic        C;
  logic        O;
  logic        Zero;
  logic        P;

  modport master (
    output X, Y,
    input  sum, S, C, O, Zero, P
  );

  modport slave (
    input  X, Y,
    output sum, S, C, O, Zero, P
  );
endinterface

// File: rtl/adder_alu16b.sv
// Registered 16-bit adder built from four 4-bit carry-lookahead blocks with rippled
// block carries; sign, carry, overflow, zero and parity flags are registered alongside.
module adder_alu16b_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is expanded from the block carry-in only, so no carry waits on another.
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign sum_o = p ^ {c[3:1], c_i};
  assign c_o   = c[4];
endmodule

module adder_alu16b (
  input  logic           clk,
  input  logic           rst_n,
  adder_alu16b_if.slave  bus
);
  logic [15:0] sum_d;
  logic [15:0] sum_q;
  logic        c4;
  logic        c8;
  logic        c12;
  logic        c16;
  logic        sign_d;
  logic        sign_q;
  logic        carry_q;
  logic        ovf_d;
  logic        ovf_q;
  logic        zero_d;
  logic        zero_q;
  logic        par_d;
  logic        par_q;

  adder_alu16b_cla4 u_blk0 (.a_i(bus.X[3:0]),   .b_i(bus.Y[3:0]),   .c_i(1'b0), .sum_o(sum_d[3:0]),   .c_o(c4));
  adder_alu16b_cla4 u_blk1 (.a_i(bus.X[7:4]),   .b_i(bus.Y[7:4]),   .c_i(c4),   .sum_o(sum_d[7:4]),   .c_o(c8));
  adder_alu16b_cla4 u_blk2 (.a_i(bus.X[11:8]),  .b_i(bus.Y[11:8]),  .c_i(c8),   .sum_o(sum_d[11:8]),  .c_o(c12));
  adder_alu16b_cla4 u_blk3 (.a_i(bus.X[15:12]), .b_i(bus.Y[15:12]), .c_i(c12),  .sum_o(sum_d[15:12]), .c_o(c16));

  always_comb begin
    sign_d = sum_d[15];
    ovf_d  = (bus.X[15] == bus.Y[15]) && (sum_d[15] != bus.X[15]);
    zero_d = ~|sum_d;
    par_d  = ~^sum_d;
  end

  // Reset values describe a zero result, so Zero and P come up set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 16'h0000;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      par_q   <= 1'b1;
    end else begin
      sum_q   <= sum_d;
      sign_q  <= sign_d;
      carry_q <= c16;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.S    = sign_q;
  assign bus.C    = carry_q;
  assign bus.O    = ovf_q;
  assign bus.Zero = zero_q;
  assign bus.P    = par_q;
endmodule

// File: tb/tb_adder_alu16b.sv
// Scoreboard bench for adder_alu16b: stimulus pushes hand-computed or reference-model
// results into a queue, and a monitor pops and compares one entry per captured edge.
module tb_adder_alu16b;
  typedef struct packed {
    logic [15:0] sum;
    logic        s;
    logic        c;
    logic        o;
    logic        zero;
    logic        p;
  } resultT;

  localparam resultT RESET_VAL = {16'h0000, 5'b00011};

  logic clk;
  logic rst_n;
  int   numChecks;
  int   numFails;
  int   vecId;
  resultT expQ[$];
  int     idQ[$];
  resultT lastExp;

  adder_alu16b_if bus ();

  adder_alu16b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Directed vectors: {sum, S, C, O, Zero, P} worked out by hand.
  logic [15:0] dirX   [10] = '{16'h0000, 16'h8FFF, 16'hFFFE, 16'hAAAA, 16'h7FFF,
                               16'hFFFF, 16'h8000, 16'h1234, 16'h0001, 16'h7FFF};
  logic [15:0] dirY   [10] = '{16'h0000, 16'h8000, 16'h0002, 16'h5555, 16'h0001,
                               16'h0001, 16'h8000, 16'h4321, 16'h0000, 16'h7FFF};
  resultT      dirExp [10] = '{{16'h0000, 5'b00011}, {16'h0FFF, 5'b01101},
                               {16'h0000, 5'b01011}, {16'hFFFF, 5'b10001},
                               {16'h8000, 5'b10100}, {16'h0000, 5'b01011},
                               {16'h0000, 5'b01111}, {16'h5555, 5'b00001},
                               {16'h0001, 5'b00000}, {16'hFFFE, 5'b10100}};

  function automatic resultT refModel(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] full;
    resultT r;
    full   = {1'b0, x} + {1'b0, y};
    r.sum  = full[15:0];
    r.c    = full[16];
    r.s    = full[15];
    r.o    = (x[15] == y[15]) && (full[15] != x[15]);
    r.zero = (full[15:0] == 16'h0000);
    r.p    = ~^full[15:0];
    return r;
  endfunction

  function automatic resultT actualNow();
    resultT r;
    r = {bus.sum, bus.S, bus.C, bus.O, bus.Zero, bus.P};
    return r;
  endfunction

  task automatic checkOutput(input string name, input int id, input resultT act, input resultT exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s #%0d: got sum=%h S%b C%b O%b Z%b P%b, want sum=%h S%b C%b O%b Z%b P%b",
               name, id, act.sum, act.s, act.c, act.o, act.zero, act.p,
               exp.sum, exp.s, exp.c, exp.o, exp.zero, exp.p);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input resultT exp);
    @(negedge clk);
    bus.X = x;
    bus.Y = y;
    expQ.push_back(exp);
    idQ.push_back(vecId);
    vecId++;
    lastExp = exp;
  endtask

  // One result per rising edge while out of reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        checkOutput("pipe", idQ.pop_front(), actualNow(), expQ.pop_front());
      end
    end
  end

  initial begin
    numChecks = 0;
    numFails  = 0;
    vecId     = 0;
    rst_n     = 1'b1;
    bus.X     = 16'h1234;
    bus.Y     = 16'h1234;
    #1 rst_n  = 1'b0;
    #1 checkOutput("resetAsync", 0, actualNow(), RESET_VAL);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 checkOutput("resetHold", i, actualNow(), RESET_VAL);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(dirX[i], dirY[i], dirExp[i]);

    // Operands moving between edges must not reach the outputs.
    @(posedge clk);
    #3;
    bus.X = 16'h0F0F;
    bus.Y = 16'h3C3C;
    #1 checkOutput("noCombPath", 0, actualNow(), lastExp);

    applyStimulus(16'h1234, 16'h4321, {16'h5555, 5'b00001});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("resetMidOp", 0, actualNow(), RESET_VAL);
    bus.X = 16'hFFFF;
    bus.Y = 16'hFFFF;
    @(posedge clk);
    #1 checkOutput("resetDiscard", 0, actualNow(), RESET_VAL);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(dirX[3], dirY[3], dirExp[3]);
    applyStimulus(dirX[4], dirY[4], dirExp[4]);

    for (int i = 0; i < 32; i++) begin
      logic [15:0] rx;
      logic [15:0] ry;
      rx = 16'($urandom);
      ry = 16'($urandom);
      applyStimulus(rx, ry, refModel(rx, ry));
    end

    repeat (2) @(posedge clk);
    #2;
    numChecks++;
    if (expQ.size() != 0) begin
      numFails++;
      $display("[TB] FAIL drain: %0d results still queued, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end
endmodule
